// File: rtl/ahbl2apb_bridge_if.sv
// Bus bundle of the AHB-Lite to APB bridge, signal names seen from the bridge side.
// With AHBL2APB_APB4_EN defined the APB4 pstrb_o/pprot_o signals are added.
interface ahbl2apb_bridge_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 16
);

  logic                   hsel_i;
  logic [ADDR_WIDTH-1:0]  haddr_i;
  logic [1:0]             htrans_i;
  logic                   hwrite_i;
  logic [2:0]             hsize_i;
  logic [DATA_WIDTH-1:0]  hwdata_i;
  logic                   hready_i;
  logic                   hreadyout_o;
  logic                   hresp_o;
  logic [DATA_WIDTH-1:0]  hrdata_o;

  logic                   psel_o;
  logic                   penable_o;
  logic                   pwrite_o;
  logic [PADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0]  pwdata_o;
  logic [DATA_WIDTH-1:0]  prdata_i;
  logic                   pready_i;
  logic                   pslverr_i;
`ifdef AHBL2APB_APB4_EN
  logic [DATA_WIDTH/8-1:0] pstrb_o;
  logic [2:0]              pprot_o;
`endif

  // Bridge side: AHB slave plus APB master
  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
           prdata_i, pready_i, pslverr_i,
    output hreadyout_o, hresp_o, hrdata_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
`ifdef AHBL2APB_APB4_EN
           , pstrb_o, pprot_o
`endif
  );

  // Environment side: AHB master/decoder plus APB peripheral
  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
           prdata_i, pready_i, pslverr_i,
    input  hreadyout_o, hresp_o, hrdata_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
`ifdef AHBL2APB_APB4_EN
           , pstrb_o, pprot_o
`endif
  );

endinterface

// File: rtl/ahbl2apb_bridge.sv
// AHB-Lite slave to APB master bridge: each accepted AHB beat becomes one APB SETUP/ACCESS pair.
// Define AHBL2APB_APB4_EN to drive APB4 pstrb_o/pprot_o; otherwise the bridge is APB3 only.
module ahbl2apb_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 16
) (
  input  logic             sys_clk_i,
  input  logic             sys_rstn_i,
  ahbl2apb_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR,
    SZERR
  } state_e;

  state_e                 state_q, state_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;

  logic                   acc;
  logic                   sizeOk;
  logic                   loadAddr;
  state_e                 acceptState;
  logic                   hreadyOut;
  logic                   hrespOut;
  logic [DATA_WIDTH-1:0]  hrdataOut;
  logic                   pselOut;
  logic                   penableOut;
  logic                   unusedBits;

  assign acc         = bus.hsel_i & bus.htrans_i[1] & bus.hready_i;
  assign sizeOk      = (bus.hsize_i <= 3'b010);
  assign acceptState = acc ? (sizeOk ? SETUP : SZERR) : IDLE;
  assign unusedBits  = ^{bus.haddr_i[ADDR_WIDTH-1:PADDR_WIDTH], bus.htrans_i[0]};

  always_comb begin
    state_d    = state_q;
    loadAddr   = 1'b0;
    hreadyOut  = 1'b1;
    hrespOut   = 1'b0;
    hrdataOut  = '0;
    pselOut    = 1'b0;
    penableOut = 1'b0;
    case (state_q)
      IDLE: begin
        state_d  = acceptState;
        loadAddr = acc & sizeOk;
      end
      SETUP: begin
        pselOut   = 1'b1;
        hreadyOut = 1'b0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        pselOut    = 1'b1;
        penableOut = 1'b1;
        if (!bus.pready_i) begin
          hreadyOut = 1'b0;
        end else if (bus.pslverr_i) begin
          hreadyOut = 1'b0;
          hrespOut  = 1'b1;
          state_d   = ERR;
        end else begin
          // Completing beat: a new address phase here goes straight to SETUP
          if (!pwrite_q) hrdataOut = bus.prdata_i;
          state_d  = acceptState;
          loadAddr = acc & sizeOk;
        end
      end
      ERR: begin
        hrespOut = 1'b1;
        state_d  = acceptState;
        loadAddr = acc & sizeOk;
      end
      SZERR: begin
        hreadyOut = 1'b0;
        hrespOut  = 1'b1;
        state_d   = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign paddr_d  = loadAddr ? bus.haddr_i[PADDR_WIDTH-1:0] : paddr_q;
  assign pwrite_d = loadAddr ? bus.hwrite_i : pwrite_q;
  assign pwdata_d = (state_q == SETUP) ? bus.hwdata_i : pwdata_q;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

`ifdef AHBL2APB_APB4_EN
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [STRB_WIDTH-1:0] strbDecoded;

  always_comb begin
    strbDecoded = '0;
    if (bus.hwrite_i) begin
      case (bus.hsize_i)
        3'b000:  strbDecoded = STRB_WIDTH'(4'b0001) << bus.haddr_i[1:0];
        3'b001:  strbDecoded = bus.haddr_i[1] ? STRB_WIDTH'(4'b1100) : STRB_WIDTH'(4'b0011);
        default: strbDecoded = STRB_WIDTH'(4'b1111);
      endcase
    end
  end

  assign pstrb_d = loadAddr ? strbDecoded : pstrb_q;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      pstrb_q <= '0;
    end else begin
      pstrb_q <= pstrb_d;
    end
  end

  assign bus.pstrb_o = pstrb_q;
  assign bus.pprot_o = 3'b000;
`endif

  // SETUP forwards the live data phase; ACCESS replays the copy taken at the end of SETUP
  assign bus.pwdata_o    = (state_q == SETUP) ? bus.hwdata_i : pwdata_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.psel_o      = pselOut;
  assign bus.penable_o   = penableOut;
  assign bus.hreadyout_o = hreadyOut;
  assign bus.hresp_o     = hrespOut;
  assign bus.hrdata_o    = hrdataOut;

endmodule

// File: tb/tb_ahbl2apb_bridge.sv
// Self-checking bench for ahbl2apb_bridge: a transaction-level model plans each AHB beat and
// its APB response, then predicts wait states, responses and APB signals cycle by cycle.
module tb_ahbl2apb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 16;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          err;
    bit          sel;
    logic [1:0]  trans;
  } txn_t;

  logic sysClk  = 1'b0;
  logic sysRstn = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  txn_t stimQ[$];
  txn_t aPh;
  txn_t dPh;
  bit   aValid = 1'b0;
  bit   dValid = 1'b0;
  int   k      = 0;

  always #5 sysClk = ~sysClk;

  ahbl2apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PADDR_WIDTH(PW)) bus ();

  ahbl2apb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PADDR_WIDTH(PW)) dut (
    .sys_clk_i (sysClk),
    .sys_rstn_i(sysRstn),
    .bus       (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  function automatic txn_t mkTxn(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int waits, input bit err);
    txn_t t;
    t.addr  = addr;
    t.write = write;
    t.size  = size;
    t.wdata = wdata;
    t.rdata = rdata;
    t.waits = waits;
    t.err   = err;
    t.sel   = 1'b1;
    t.trans = 2'b10;
    return t;
  endfunction

  function automatic bit isXfer(input txn_t t);
    return t.sel && t.trans[1];
  endfunction

  function automatic bit sizeErr(input txn_t t);
    return t.size > 3'd2;
  endfunction

`ifdef AHBL2APB_APB4_EN
  function automatic logic [3:0] expStrb(input txn_t t);
    if (!t.write) return 4'b0000;
    case (t.size)
      3'd0:    return 4'b0001 << t.addr[1:0];
      3'd1:    return t.addr[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction
`endif

  task automatic driveIdle();
    bus.hsel_i    = 1'b0;
    bus.htrans_i  = 2'b00;
    bus.haddr_i   = '0;
    bus.hwrite_i  = 1'b0;
    bus.hsize_i   = 3'b010;
    bus.hwdata_i  = '0;
    bus.hready_i  = 1'b1;
    bus.prdata_i  = '0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
  endtask

  // One bus cycle: advance the model at the edge, drive both buses, then check at the negedge
  task automatic applyStimulus();
    logic hrdy;
    logic expReady;
    logic expResp;
    int   comp;
    @(posedge sysClk);
    hrdy = bus.hready_i;
    #1;
    if (hrdy) begin
      dValid = aValid && isXfer(aPh);
      dPh    = aPh;
      k      = 1;
      if (stimQ.size() > 0) begin
        aPh    = stimQ.pop_front();
        aValid = 1'b1;
      end else begin
        aValid = 1'b0;
      end
    end else begin
      k++;
    end
    comp     = 2 + dPh.waits;
    expReady = 1'b1;
    expResp  = 1'b0;
    if (dValid) begin
      if (sizeErr(dPh)) begin
        expReady = (k >= 2);
        expResp  = 1'b1;
      end else if (k < comp) begin
        expReady = 1'b0;
      end else if (k == comp) begin
        expReady = !dPh.err;
        expResp  = dPh.err;
      end else begin
        expResp  = 1'b1;
      end
    end

    bus.hready_i = expReady;
    bus.hsel_i   = aValid ? aPh.sel : 1'b0;
    bus.htrans_i = aValid ? aPh.trans : 2'b00;
    bus.haddr_i  = aValid ? aPh.addr : $urandom();
    bus.hwrite_i = aValid ? aPh.write : 1'($urandom());
    bus.hsize_i  = aValid ? aPh.size : 3'($urandom());
    bus.hwdata_i = (dValid && dPh.write) ? dPh.wdata : $urandom();

    bus.pready_i  = 1'($urandom());
    bus.pslverr_i = 1'($urandom());
    bus.prdata_i  = $urandom();
    if (dValid && !sizeErr(dPh) && k >= 2 && k <= comp) begin
      bus.pready_i = (k == comp);
      if (k == comp) begin
        bus.pslverr_i = dPh.err;
        bus.prdata_i  = dPh.rdata;
      end
    end

    @(negedge sysClk);
    checkOutput("hreadyout", bus.hreadyout_o, expReady);
    checkOutput("hresp", bus.hresp_o, expResp);
    if (!dValid || sizeErr(dPh)) begin
      checkOutput("idle_psel", bus.psel_o, 1'b0);
      checkOutput("idle_penable", bus.penable_o, 1'b0);
      checkOutput("idle_hrdata", bus.hrdata_o, 32'h0);
    end else begin
      if (k == 1) begin
        checkOutput("setup_psel", bus.psel_o, 1'b1);
        checkOutput("setup_penable", bus.penable_o, 1'b0);
      end else if (k <= comp) begin
        checkOutput("access_psel", bus.psel_o, 1'b1);
        checkOutput("access_penable", bus.penable_o, 1'b1);
      end else begin
        checkOutput("err_psel", bus.psel_o, 1'b0);
        checkOutput("err_penable", bus.penable_o, 1'b0);
      end
      if (k <= comp) begin
        checkOutput("paddr", bus.paddr_o, dPh.addr[PW-1:0]);
        checkOutput("pwrite", bus.pwrite_o, dPh.write);
        if (dPh.write) checkOutput("pwdata", bus.pwdata_o, dPh.wdata);
`ifdef AHBL2APB_APB4_EN
        checkOutput("pstrb", bus.pstrb_o, expStrb(dPh));
        checkOutput("pprot", bus.pprot_o, 3'b000);
`endif
      end
      if (k != comp) begin
        checkOutput("hrdata_zero", bus.hrdata_o, 32'h0);
      end else if (!dPh.err) begin
        checkOutput("hrdata", bus.hrdata_o, dPh.write ? 32'h0 : dPh.rdata);
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((stimQ.size() > 0 || aValid || dValid) && guard < 20000) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 20000) checkOutput("drain_bound", guard, 0);
  endtask

  task automatic checkResetState(input string phase);
    checkOutput({phase, "_hreadyout"}, bus.hreadyout_o, 1'b1);
    checkOutput({phase, "_hresp"}, bus.hresp_o, 1'b0);
    checkOutput({phase, "_hrdata"}, bus.hrdata_o, 32'h0);
    checkOutput({phase, "_psel"}, bus.psel_o, 1'b0);
    checkOutput({phase, "_penable"}, bus.penable_o, 1'b0);
    checkOutput({phase, "_pwrite"}, bus.pwrite_o, 1'b0);
    checkOutput({phase, "_paddr"}, bus.paddr_o, 16'h0);
    checkOutput({phase, "_pwdata"}, bus.pwdata_o, 32'h0);
  endtask

  initial begin
    txn_t t;
    int   guard;
    driveIdle();
    repeat (2) @(negedge sysClk);
    checkResetState("reset");
    sysRstn = 1'b1;

    // Directed beats queued back to back, with idle/unselected beats in between
    stimQ.push_back(mkTxn(32'h4000_0010, 1'b1, 3'b010, 32'h1234_5678, 32'h0, 0, 1'b0));
    stimQ.push_back(mkTxn(32'h4000_0004, 1'b0, 3'b010, 32'h0, 32'hCAFE_BABE, 3, 1'b0));
    t = mkTxn(32'h4000_0100, 1'b1, 3'b010, 32'hDEAD_0001, 32'h0, 0, 1'b0);
    t.trans = 2'b00;
    stimQ.push_back(t);
    stimQ.push_back(mkTxn(32'h4000_0020, 1'b0, 3'b010, 32'h0, 32'h5555_AAAA, 0, 1'b1));
    t = mkTxn(32'h4000_0200, 1'b0, 3'b000, 32'h0, 32'h0, 0, 1'b0);
    t.sel = 1'b0;
    stimQ.push_back(t);
    stimQ.push_back(mkTxn(32'h4000_0008, 1'b1, 3'b010, 32'hA5A5_0008, 32'h0, 0, 1'b0));
    stimQ.push_back(mkTxn(32'h4000_000C, 1'b0, 3'b010, 32'h0, 32'h0BAD_F00D, 1, 1'b0));
    stimQ.push_back(mkTxn(32'h4000_0030, 1'b1, 3'b011, 32'h7777_7777, 32'h0, 0, 1'b0));
    stimQ.push_back(mkTxn(32'h4000_0041, 1'b1, 3'b000, 32'h0000_00EE, 32'h0, 2, 1'b0));
    stimQ.push_back(mkTxn(32'h4000_0042, 1'b1, 3'b001, 32'hBEEF_0000, 32'h0, 0, 1'b0));
    drain();

    // Reset while an ACCESS is stalled on pready low
    stimQ.push_back(mkTxn(32'h4000_0050, 1'b0, 3'b010, 32'h0, 32'h1111_2222, 6, 1'b0));
    guard = 0;
    while (!(dValid && k == 3) && guard < 50) begin
      applyStimulus();
      guard++;
    end
    checkOutput("reach_access", guard < 50, 1'b1);
    sysRstn = 1'b0;
    #1;
    checkResetState("midreset");
    stimQ.delete();
    aValid = 1'b0;
    dValid = 1'b0;
    k      = 0;
    driveIdle();
    @(negedge sysClk);
    checkResetState("heldreset");
    sysRstn = 1'b1;
    stimQ.push_back(mkTxn(32'h4000_0060, 1'b1, 3'b010, 32'h600D_CAFE, 32'h0, 0, 1'b0));
    stimQ.push_back(mkTxn(32'h4000_0060, 1'b0, 3'b010, 32'h0, 32'h600D_CAFE, 0, 1'b0));
    drain();

    // Random mix of sizes, waits, errors and non-transfers
    for (int i = 0; i < 250; i++) begin
      int r;
      t = mkTxn($urandom(), 1'($urandom()), 3'($urandom_range(0, 2)), $urandom(), $urandom(),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) t.size = 3'($urandom_range(3, 7));
      t.trans = 2'($urandom_range(2, 3));
      r = int'($urandom_range(0, 7));
      if (r == 0) t.sel = 1'b0;
      if (r == 1) t.trans = 2'($urandom_range(0, 1));
      stimQ.push_back(t);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
